// File: rtl/pll_pkg.sv
// Shared types and constants for the ECP5 EHXPLLL dynamic phase-shift controller.
package pll_pkg;

  typedef enum logic [1:0] {
    CLKOS  = 2'd0,
    CLKOS2 = 2'd1,
    CLKOS3 = 2'd2,
    CLKOP  = 2'd3
  } pll_out_sel_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STEP_PULSE,
    ST_STEP_GAP,
    ST_LOAD_PULSE,
    ST_LOAD_GAP,
    ST_DONE
  } pll_state_e;

  // PHASESTEP/PHASELOADREG are active-low pulses, so their resting level is high.
  localparam logic PHASE_PULSE_IDLE = 1'b1;
  localparam logic PHASE_DIR_RESET  = 1'b1;
  localparam int   TIMER_W          = 8;

endpackage

// File: rtl/pll_phase_timer.sv
// Shared down-counter for every timed FSM state; expired marks the last cycle of a window.
module pll_phase_timer
  import pll_pkg::*;
(
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  output logic               expired
);

  logic [TIMER_W-1:0] count;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - TIMER_W'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/pll_phase_ctrl_ecp5.sv
// Sequences PHASESEL/PHASEDIR/PHASESTEP/PHASELOADREG for the ECP5 PLL and tracks per-output phase offsets.
module pll_phase_ctrl_ecp5
  import pll_pkg::*;
#(
  parameter int SETUP_CYC  = 2,
  parameter int STEP_LOW   = 4,
  parameter int SETTLE_CYC = 8,
  parameter int STEP_W     = 8,
  parameter int POS_W      = 8
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 pll_locked,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_sel,
  input  logic                 req_dir,
  input  logic [STEP_W-1:0]    req_steps,
  input  logic                 req_load,
  output logic                 done,
  output logic                 err,
  output logic                 busy,
  output logic [4*POS_W-1:0]   phase_off,
  output logic [1:0]           pll_phasesel,
  output logic                 pll_phasedir,
  output logic                 pll_phasestep,
  output logic                 pll_phaseloadreg
);

  localparam logic [POS_W-1:0]  OFF_ONE  = POS_W'(1);
  localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);

  pll_state_e             state;
  logic [STEP_W-1:0]      steps_left;
  logic                   load_pending;
  logic [3:0][POS_W-1:0]  offsets;
  logic                   timer_load;
  logic [TIMER_W-1:0]     timer_val;
  logic                   timer_expired;

  assign phase_off = offsets;

  // The timer is reloaded on every state change with the length of the state being entered.
  always_comb begin
    timer_load = (state == ST_IDLE) || (state == ST_DONE) || timer_expired;
    timer_val  = TIMER_W'(STEP_LOW - 1);
    if (state == ST_IDLE) begin
      timer_val = TIMER_W'(SETUP_CYC - 1);
    end else if (state == ST_STEP_PULSE || state == ST_LOAD_PULSE) begin
      timer_val = TIMER_W'(SETTLE_CYC - 1);
    end
  end

  pll_phase_timer u_timer (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .load     (timer_load),
    .load_val (timer_val),
    .expired  (timer_expired)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state            <= ST_IDLE;
      steps_left       <= '0;
      load_pending     <= 1'b0;
      offsets          <= '0;
      req_ready        <= 1'b1;
      done             <= 1'b0;
      err              <= 1'b0;
      busy             <= 1'b0;
      pll_phasesel     <= CLKOS;
      pll_phasedir     <= PHASE_DIR_RESET;
      pll_phasestep    <= PHASE_PULSE_IDLE;
      pll_phaseloadreg <= PHASE_PULSE_IDLE;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (state != ST_IDLE && !pll_locked) begin
        // A step in its settle window already had its full pulse, so the PLL did move.
        if (state == ST_STEP_GAP) begin
          offsets[pll_phasesel] <= pll_phasedir ? offsets[pll_phasesel] + OFF_ONE
                                                : offsets[pll_phasesel] - OFF_ONE;
        end
        state            <= ST_IDLE;
        err              <= 1'b1;
        busy             <= 1'b0;
        req_ready        <= 1'b0;
        pll_phasestep    <= PHASE_PULSE_IDLE;
        pll_phaseloadreg <= PHASE_PULSE_IDLE;
      end else begin
        unique case (state)
          ST_IDLE: begin
            req_ready <= 1'b1;
            if (req_valid && req_ready && pll_locked) begin
              pll_phasesel <= req_sel;
              pll_phasedir <= req_dir;
              steps_left   <= req_steps;
              load_pending <= req_load;
              req_ready    <= 1'b0;
              busy         <= 1'b1;
              state        <= ST_SETUP;
            end
          end
          ST_SETUP: begin
            if (timer_expired) begin
              if (steps_left != '0) begin
                pll_phasestep <= 1'b0;
                state         <= ST_STEP_PULSE;
              end else if (load_pending) begin
                pll_phaseloadreg <= 1'b0;
                state            <= ST_LOAD_PULSE;
              end else begin
                done  <= 1'b1;
                state <= ST_DONE;
              end
            end
          end
          ST_STEP_PULSE: begin
            if (timer_expired) begin
              pll_phasestep <= PHASE_PULSE_IDLE;
              state         <= ST_STEP_GAP;
            end
          end
          ST_STEP_GAP: begin
            if (timer_expired) begin
              steps_left            <= steps_left - STEP_ONE;
              offsets[pll_phasesel] <= pll_phasedir ? offsets[pll_phasesel] + OFF_ONE
                                                    : offsets[pll_phasesel] - OFF_ONE;
              if (steps_left != STEP_ONE) begin
                pll_phasestep <= 1'b0;
                state         <= ST_STEP_PULSE;
              end else if (load_pending) begin
                pll_phaseloadreg <= 1'b0;
                state            <= ST_LOAD_PULSE;
              end else begin
                done  <= 1'b1;
                state <= ST_DONE;
              end
            end
          end
          ST_LOAD_PULSE: begin
            if (timer_expired) begin
              pll_phaseloadreg <= PHASE_PULSE_IDLE;
              state            <= ST_LOAD_GAP;
            end
          end
          ST_LOAD_GAP: begin
            if (timer_expired) begin
              done  <= 1'b1;
              state <= ST_DONE;
            end
          end
          ST_DONE: begin
            busy      <= 1'b0;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end
          default: begin
            busy      <= 1'b0;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pll_phase_ctrl_ecp5.sv
// Directed bench for pll_phase_ctrl_ecp5: pulse timing, offsets, lock loss, wrap and reset.
module tb_pll_phase_ctrl_ecp5;
  import pll_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        pll_locked = 1'b1;
  logic        req_valid = 1'b0;
  logic [1:0]  req_sel = 2'b00;
  logic        req_dir = 1'b0;
  logic [7:0]  req_steps = 8'd0;
  logic        req_load = 1'b0;
  logic        req_ready, done, err, busy;
  logic [31:0] phase_off;
  logic [1:0]  pll_phasesel;
  logic        pll_phasedir, pll_phasestep, pll_phaseloadreg;

  int checks = 0;
  int errors = 0;

  int   step_starts[$];
  int   load_starts[$];
  int   step_low_cnt, load_low_cnt, done_cnt, done_cycle, err_cnt, err_cycle;
  logic k1_busy, k1_ready, k1_dir, step_at_err, finished;
  logic [1:0] k1_sel;

  pll_phase_ctrl_ecp5 dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .pll_locked       (pll_locked),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_sel          (req_sel),
    .req_dir          (req_dir),
    .req_steps        (req_steps),
    .req_load         (req_load),
    .done             (done),
    .err              (err),
    .busy             (busy),
    .phase_off        (phase_off),
    .pll_phasesel     (pll_phasesel),
    .pll_phasedir     (pll_phasedir),
    .pll_phasestep    (pll_phasestep),
    .pll_phaseloadreg (pll_phaseloadreg)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] off_of(input int idx);
    return {24'd0, phase_off[idx*8 +: 8]};
  endfunction

  function automatic int q_at(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  // Cycle k is sampled at the k-th falling edge after the accepting rising edge.
  task automatic apply_stimulus(input logic [1:0] sel, input logic dir, input logic [7:0] steps,
                                input logic load, input int drop_pulse, input int budget);
    logic prev_step, prev_load;
    step_starts.delete();
    load_starts.delete();
    step_low_cnt = 0; load_low_cnt = 0; done_cnt = 0; err_cnt = 0;
    done_cycle = -1; err_cycle = -1; step_at_err = 1'b0; finished = 1'b0;
    prev_step = 1'b1; prev_load = 1'b1;
    @(negedge clk_in);
    req_sel = sel; req_dir = dir; req_steps = steps; req_load = load; req_valid = 1'b1;
    for (int k = 1; k <= budget && !finished; k++) begin
      @(negedge clk_in);
      if (k == 1) begin
        k1_sel = pll_phasesel; k1_dir = pll_phasedir; k1_busy = busy; k1_ready = req_ready;
        req_valid = 1'b0;
      end
      if (!pll_phasestep) begin
        step_low_cnt++;
        if (prev_step) begin
          step_starts.push_back(k);
          if (step_starts.size() == drop_pulse) pll_locked = 1'b0;
        end
      end
      if (!pll_phaseloadreg) begin
        load_low_cnt++;
        if (prev_load) load_starts.push_back(k);
      end
      prev_step = pll_phasestep;
      prev_load = pll_phaseloadreg;
      if (done) begin done_cnt++; done_cycle = k; finished = 1'b1; end
      if (err) begin
        err_cnt++; err_cycle = k; step_at_err = pll_phasestep; finished = 1'b1;
        pll_locked = 1'b1;
      end
    end
    check_output("request_finished", {31'd0, finished}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    #12;
    check_output("rst_ready", {31'd0, req_ready}, 32'd1);
    check_output("rst_done", {31'd0, done}, 32'd0);
    check_output("rst_err", {31'd0, err}, 32'd0);
    check_output("rst_busy", {31'd0, busy}, 32'd0);
    check_output("rst_phase_off", phase_off, 32'd0);
    check_output("rst_phasesel", {30'd0, pll_phasesel}, 32'd0);
    check_output("rst_phasedir", {31'd0, pll_phasedir}, 32'd1);
    check_output("rst_phasestep", {31'd0, pll_phasestep}, 32'd1);
    check_output("rst_loadreg", {31'd0, pll_phaseloadreg}, 32'd1);
    @(negedge clk_in);
    rst_in = 1'b0;
    repeat (2) @(negedge clk_in);
    check_output("post_rst_ready", {31'd0, req_ready}, 32'd1);
    check_output("post_rst_step", {31'd0, pll_phasestep}, 32'd1);
    check_output("post_rst_loadreg", {31'd0, pll_phaseloadreg}, 32'd1);

    $display("[TB] sel=CLKOS2 advance 3 steps");
    apply_stimulus(CLKOS2, 1'b1, 8'd3, 1'b0, 0, 100);
    check_output("a_sel", {30'd0, k1_sel}, 32'd1);
    check_output("a_dir", {31'd0, k1_dir}, 32'd1);
    check_output("a_busy", {31'd0, k1_busy}, 32'd1);
    check_output("a_ready", {31'd0, k1_ready}, 32'd0);
    check_output("a_pulses", step_starts.size(), 32'd3);
    check_output("a_start0", q_at(step_starts, 0), 32'd3);
    check_output("a_start1", q_at(step_starts, 1), 32'd15);
    check_output("a_start2", q_at(step_starts, 2), 32'd27);
    check_output("a_low_cycles", step_low_cnt, 32'd12);
    check_output("a_load_low", load_low_cnt, 32'd0);
    check_output("a_done_cycle", done_cycle, 32'd39);
    check_output("a_err", err_cnt, 32'd0);
    check_output("a_off1", off_of(1), 32'h03);
    @(negedge clk_in);
    check_output("a_ready_after", {31'd0, req_ready}, 32'd1);
    check_output("a_busy_after", {31'd0, busy}, 32'd0);
    check_output("a_done_one_cycle", {31'd0, done}, 32'd0);

    $display("[TB] sel=CLKOP delay 2 steps plus load");
    apply_stimulus(CLKOP, 1'b0, 8'd2, 1'b1, 0, 100);
    check_output("b_sel", {30'd0, k1_sel}, 32'd3);
    check_output("b_dir", {31'd0, k1_dir}, 32'd0);
    check_output("b_pulses", step_starts.size(), 32'd2);
    check_output("b_start1", q_at(step_starts, 1), 32'd15);
    check_output("b_load_start", q_at(load_starts, 0), 32'd27);
    check_output("b_load_low", load_low_cnt, 32'd4);
    check_output("b_done_cycle", done_cycle, 32'd39);
    check_output("b_off3", off_of(3), 32'hFE);
    check_output("b_off1_kept", off_of(1), 32'h03);

    $display("[TB] lock loss during second pulse");
    apply_stimulus(CLKOS3, 1'b1, 8'd4, 1'b0, 2, 100);
    check_output("c_pulses", step_starts.size(), 32'd2);
    check_output("c_start1", q_at(step_starts, 1), 32'd15);
    check_output("c_err_cycle", err_cycle, 32'd16);
    check_output("c_done", done_cnt, 32'd0);
    check_output("c_step_high", {31'd0, step_at_err}, 32'd1);
    check_output("c_off2", off_of(2), 32'h01);
    @(negedge clk_in);
    check_output("c_ready_after", {31'd0, req_ready}, 32'd1);
    check_output("c_err_one_cycle", {31'd0, err}, 32'd0);
    check_output("c_busy_after", {31'd0, busy}, 32'd0);

    $display("[TB] zero steps, no load");
    apply_stimulus(CLKOS, 1'b1, 8'd0, 1'b0, 0, 100);
    check_output("d_done_cycle", done_cycle, 32'd3);
    check_output("d_step_low", step_low_cnt, 32'd0);
    check_output("d_load_low", load_low_cnt, 32'd0);
    check_output("d_off0", off_of(0), 32'h00);

    $display("[TB] 130 advance steps wrap on CLKOS");
    apply_stimulus(CLKOS, 1'b1, 8'd130, 1'b0, 0, 1700);
    check_output("e_pulses", step_starts.size(), 32'd130);
    check_output("e_done_cycle", done_cycle, 32'd1563);
    check_output("e_off0", off_of(0), 32'h82);

    $display("[TB] request while unlocked");
    @(negedge clk_in);
    pll_locked = 1'b0;
    req_sel = CLKOP; req_steps = 8'd1; req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_in);
      check_output("f_busy", {31'd0, busy}, 32'd0);
      check_output("f_ready", {31'd0, req_ready}, 32'd1);
    end
    check_output("f_sel_held", {30'd0, pll_phasesel}, 32'd0);
    req_valid = 1'b0;
    pll_locked = 1'b1;

    $display("[TB] asynchronous reset mid-pulse");
    @(negedge clk_in);
    req_sel = CLKOS2; req_dir = 1'b0; req_steps = 8'd2; req_load = 1'b0; req_valid = 1'b1;
    @(negedge clk_in);
    req_valid = 1'b0;
    repeat (4) @(negedge clk_in);
    check_output("g_pre_step", {31'd0, pll_phasestep}, 32'd0);
    check_output("g_pre_dir", {31'd0, pll_phasedir}, 32'd0);
    #2 rst_in = 1'b1;
    #1;
    check_output("g_phase_off", phase_off, 32'd0);
    check_output("g_step", {31'd0, pll_phasestep}, 32'd1);
    check_output("g_dir", {31'd0, pll_phasedir}, 32'd1);
    check_output("g_sel", {30'd0, pll_phasesel}, 32'd0);
    check_output("g_busy", {31'd0, busy}, 32'd0);
    check_output("g_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
